mac_ack_sequencer: RTL and testbench



---
 rtl/mac_ack_sequencer.sv | 125 ++++++++++++
 tb/tb_mac_ack_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_ack_sequencer.sv
// mac_ack_sequencer: counts upstream input acknowledges up to a programmable
// limit, then raises ack_mac toward the MAC/neuron stage. It sequences
// NUM_PASSES neuron passes per layer and reports layer completion and
// protocol errors. All state updates happen on the falling edge of clk.
module mac_ack_sequencer #(
  parameter int CNT_W         = 8,
  parameter int LIMIT_DEFAULT = 2,
  parameter int NUM_PASSES    = 1,
  parameter int PASS_W        = 4,
  parameter bit STICKY        = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  limit,
  input  logic              ack,
  input  logic              mac_taken,
  output logic [CNT_W-1:0]  idx,
  output logic              ack_mac,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              layer_done,
  output logic              err_ack
);

  // HOLD is only reachable when STICKY=1.
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  localparam logic [CNT_W-1:0]  LIMIT_DEF = CNT_W'(LIMIT_DEFAULT);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  state_t           state;
  logic [CNT_W-1:0] limit_r;
  logic [CNT_W-1:0] last_idx;
  logic             terminal;
  logic             advance;

  // limit_r is never zero, so last_idx never underflows.
  assign last_idx = limit_r - CNT_W'(1);
  assign terminal = (state == COUNT) && ack && (idx == last_idx);
  // A neuron completes either on the terminal ack (pulse mode) or when the
  // consumer takes the held ack_mac (sticky mode). start pre-empts both.
  assign advance  = !start &&
                    ((terminal && !STICKY) || ((state == HOLD) && mac_taken));

  // Main sequencer: reset, start/abort, counting, hold and pass advance.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(negedge clk) begin
    if (rst) begin
      state      <= IDLE;
      limit_r    <= LIMIT_DEF;
      idx        <= '0;
      ack_mac    <= 1'b0;
      pass_idx   <= '0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
      err_ack    <= 1'b0;
    end else if (start) begin
      // Starting from IDLE or aborting a running layer look identical;
      // a coincident ack is ignored.
      state      <= COUNT;
      limit_r    <= (limit == '0) ? LIMIT_DEF : limit;
      idx        <= '0;
      ack_mac    <= 1'b0;
      pass_idx   <= '0;
      busy       <= 1'b1;
      layer_done <= 1'b0;
      err_ack    <= 1'b0;
    end else begin
      // In pulse mode ack_mac lasts exactly one cycle unless re-raised below.
      if (!STICKY) begin
        ack_mac <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ack) begin
            err_ack <= 1'b1;
          end
        end

        COUNT: begin
          if (ack) begin
            if (terminal) begin
              idx     <= '0;
              ack_mac <= 1'b1;
              if (STICKY) begin
                state <= HOLD;
              end
            end else begin
              idx <= idx + CNT_W'(1);
            end
          end
        end

        HOLD: begin
          // Acks here are never counted, even alongside mac_taken.
          if (ack) begin
            err_ack <= 1'b1;
          end
          if (mac_taken) begin
            ack_mac <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Pass advance overrides the next-state chosen above.
      if (advance) begin
        if (pass_idx == LAST_PASS) begin
          layer_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end else begin
          pass_idx <= pass_idx + PASS_W'(1);
          state    <= COUNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_ack_sequencer.sv
// Testbench for mac_ack_sequencer. Two instances share one stimulus stream:
// dut_a uses the defaults (sticky ack_mac, one pass), dut_b uses three passes
// with pulsed ack_mac. Each is compared every cycle against a behavioural
// model that tracks accepted acks per neuron with modular arithmetic.
module tb_mac_ack_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] limit;
  logic       ack;
  logic       mac_taken;

  logic [7:0] idx_a,      idx_b;
  logic       ack_mac_a,  ack_mac_b;
  logic [3:0] pass_idx_a, pass_idx_b;
  logic       busy_a,     busy_b;
  logic       done_a,     done_b;
  logic       err_a,      err_b;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  typedef struct {
    int lim;      // inputs per neuron in force
    int cnt;      // accepted acks in the current neuron, mod lim
    int pass;     // current pass
    bit waiting;  // neuron complete, waiting for mac_taken
    bit active;   // layer running
    bit done;     // layer finished
    bit err;      // protocol error seen
    bit pulse;    // neuron completed at the last edge (pulse mode)
  } model_t;

  model_t m_a, m_b;

  mac_ack_sequencer #(
    .CNT_W(8), .LIMIT_DEFAULT(2), .NUM_PASSES(1), .PASS_W(4), .STICKY(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .limit(limit), .ack(ack),
    .mac_taken(mac_taken), .idx(idx_a), .ack_mac(ack_mac_a),
    .pass_idx(pass_idx_a), .busy(busy_a), .layer_done(done_a), .err_ack(err_a)
  );

  mac_ack_sequencer #(
    .CNT_W(8), .LIMIT_DEFAULT(2), .NUM_PASSES(3), .PASS_W(4), .STICKY(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .limit(limit), .ack(ack),
    .mac_taken(mac_taken), .idx(idx_b), .ack_mac(ack_mac_b),
    .pass_idx(pass_idx_b), .busy(busy_b), .layer_done(done_b), .err_ack(err_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // A finished neuron either moves to the next pass or ends the layer.
  task automatic finish_neuron(inout model_t s, input int np);
    if (s.pass == np - 1) begin
      s.done   = 1'b1;
      s.active = 1'b0;
    end else begin
      s.pass++;
    end
  endtask

  task automatic model_step(inout model_t s, input bit sticky, input int np,
                            input bit r, input bit st, input bit a,
                            input bit mt, input int lim_in);
    s.pulse = 1'b0;
    if (r) begin
      s = '{lim: 2, cnt: 0, pass: 0, waiting: 1'b0, active: 1'b0,
            done: 1'b0, err: 1'b0, pulse: 1'b0};
    end else if (st) begin
      s = '{lim: (lim_in == 0) ? 2 : lim_in, cnt: 0, pass: 0, waiting: 1'b0,
            active: 1'b1, done: 1'b0, err: 1'b0, pulse: 1'b0};
    end else if (!s.active) begin
      if (a) s.err = 1'b1;
    end else if (s.waiting) begin
      if (a) s.err = 1'b1;
      if (mt) begin
        s.waiting = 1'b0;
        finish_neuron(s, np);
      end
    end else if (a) begin
      s.cnt = (s.cnt + 1) % s.lim;
      if (s.cnt == 0) begin
        if (sticky) begin
          s.waiting = 1'b1;
        end else begin
          s.pulse = 1'b1;
          finish_neuron(s, np);
        end
      end
    end
  endtask

  task automatic compare_a();
    check("a.idx",        32'(idx_a),      32'(m_a.cnt));
    check("a.ack_mac",    32'(ack_mac_a),  32'(m_a.waiting));
    check("a.pass_idx",   32'(pass_idx_a), 32'(m_a.pass));
    check("a.busy",       32'(busy_a),     32'(m_a.active));
    check("a.layer_done", 32'(done_a),     32'(m_a.done));
    check("a.err_ack",    32'(err_a),      32'(m_a.err));
  endtask

  task automatic compare_b();
    check("b.idx",        32'(idx_b),      32'(m_b.cnt));
    check("b.ack_mac",    32'(ack_mac_b),  32'(m_b.pulse));
    check("b.pass_idx",   32'(pass_idx_b), 32'(m_b.pass));
    check("b.busy",       32'(busy_b),     32'(m_b.active));
    check("b.layer_done", 32'(done_b),     32'(m_b.done));
    check("b.err_ack",    32'(err_b),      32'(m_b.err));
  endtask

  // One clock: compare on the rising edge, drive, let both DUT and model
  // take the same inputs on the falling edge.
  task automatic cycle(input bit r, input bit st, input bit a, input bit mt,
                       input int lim);
    @(posedge clk);
    #1;
    if (checking) begin
      compare_a();
      compare_b();
    end
    rst       = r;
    start     = st;
    ack       = a;
    mac_taken = mt;
    limit     = 8'(lim);
    @(negedge clk);
    model_step(m_a, 1'b1, 1, r, st, a, mt, lim);
    model_step(m_b, 1'b0, 3, r, st, a, mt, lim);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ack = 1'b0; mac_taken = 1'b0; limit = '0;

    // Reset, then default limit: two acks complete the neuron.
    cycle(1, 0, 0, 0, 0);
    checking = 1'b1;
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);

    // limit=4, twelve acks: three passes on dut_b; dut_a parks in HOLD.
    cycle(0, 1, 0, 0, 4);
    for (int i = 0; i < 12; i++) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);

    // limit=3, ack held high through HOLD, mac_taken coincident with ack.
    cycle(0, 1, 0, 0, 3);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // limit=1: every accepted ack completes a neuron.
    cycle(0, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1'(i % 2), 0);
    cycle(0, 0, 0, 1, 0);

    // limit=255: ack_mac only after the 255th ack, idx wraps to 0.
    cycle(0, 1, 0, 0, 255);
    for (int i = 0; i < 258; i++) cycle(0, 0, 1, 1'(i >= 255), 0);
    cycle(0, 0, 0, 0, 0);

    // Abort at idx=5 with a coincident ack, then rst while dut_a is in HOLD.
    cycle(0, 1, 0, 0, 8);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 1, 0, 8);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 2);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Ack in IDLE before any start sets err_ack; start clears it.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 3);
    cycle(0, 0, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      int lim_r;
      lim_r = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 6));
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, lim_r);
    end
    cycle(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
